// File: rtl/pattern_resp_pkg.sv
// Shared types and constants for the pattern response MISR compactor.
package pattern_resp_pkg;

    // Control FSM states for the capture run
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FLUSH   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_e;

    // x^16 + x^14 + x^13 + x^11 + 1, Galois (right-shifting) form
    localparam logic [15:0] DEFAULT_POLY = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hFFFF;

    // Bit positions of the upstream output nets inside resp_in
    localparam int RESP_NETS         = 9;
    localparam int IDX_G42_1         = 8;
    localparam int IDX_N_572_1       = 7;
    localparam int IDX_N_573_1       = 6;
    localparam int IDX_N_549_1       = 5;
    localparam int IDX_N_569_1       = 4;
    localparam int IDX_ACVQN2_3      = 3;
    localparam int IDX_N_266_AND_0_3 = 2;
    localparam int IDX_ACVQN1_5      = 1;
    localparam int IDX_P6_5          = 0;

endpackage

// File: rtl/pattern_resp_misr_core.sv
// Combinational next-state function of a Galois MISR. Kept separate so the
// feedback polynomial can be changed without touching the control FSM.
module misr_core
    import pattern_resp_pkg::*;
#(
    parameter int               SIG_W  = 16,
    parameter int               RESP_W = RESP_NETS,
    parameter logic [SIG_W-1:0] POLY   = DEFAULT_POLY
) (
    input  logic [SIG_W-1:0]  sig,
    input  logic [RESP_W-1:0] data,
    output logic [SIG_W-1:0]  sig_nxt
);

    logic [SIG_W-1:0] fb_term;

    // Shift right, fold in the taps when the LSB falls out, inject the data
    always_comb begin
        fb_term = sig[0] ? POLY : '0;
        sig_nxt = (sig >> 1) ^ fb_term ^ SIG_W'(data);
    end

endmodule

// File: rtl/pattern_resp_misr.sv
// Response compactor: registers the upstream outputs, folds them into a MISR
// over a programmable window and hands the signature out via valid/ready.
// Optional build macro PATTERN_RESP_MISR_MASK_EN adds a resp_mask input that
// zeroes selected (X-prone) response bits before they reach the MISR.
module pattern_resp_misr
    import pattern_resp_pkg::*;
#(
    parameter int               RESP_W  = RESP_NETS,
    parameter int               SIG_W   = 16,
    parameter logic [SIG_W-1:0] POLY    = DEFAULT_POLY,
    parameter logic [SIG_W-1:0] SEED    = DEFAULT_SEED,
    parameter int               SETTLE  = 2,
    parameter int               WIN_LEN = 256
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              start,
    input  logic [RESP_W-1:0] resp_in,
`ifdef PATTERN_RESP_MISR_MASK_EN
    input  logic [RESP_W-1:0] resp_mask,
`endif
    input  logic [SIG_W-1:0]  exp_sig,
    output logic              busy,
    output logic              sig_valid,
    input  logic              sig_ready,
    output logic [SIG_W-1:0]  sig_data,
    output logic              pass
);

    // Counter spans both the settle and capture phases and never wraps
    localparam int MAX_CNT = (WIN_LEN > SETTLE) ? WIN_LEN : SETTLE;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam int SET_M1  = (SETTLE > 0) ? SETTLE - 1 : 0;
    localparam int WIN_M1  = (WIN_LEN > 0) ? WIN_LEN - 1 : 0;
    localparam logic [CNT_W-1:0] SETTLE_LAST = SET_M1[CNT_W-1:0];
    localparam logic [CNT_W-1:0] WIN_LAST    = WIN_M1[CNT_W-1:0];

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SIG_W-1:0]  sig_q, sig_d;
    logic [RESP_W-1:0] resp_q, resp_d;
    logic              sig_valid_q, sig_valid_d;
    logic [SIG_W-1:0]  sig_data_q, sig_data_d;
    logic              pass_q, pass_d;
    logic [RESP_W-1:0] inj;
    logic [SIG_W-1:0]  misr_nxt;
    logic              hs;

    assign hs = sig_valid_q & sig_ready;

    // Term injected into the MISR, optionally with masked bits forced to 0
    always_comb begin
`ifdef PATTERN_RESP_MISR_MASK_EN
        inj = resp_q & ~resp_mask;
`else
        inj = resp_q;
`endif
    end

    misr_core #(
        .SIG_W  (SIG_W),
        .RESP_W (RESP_W),
        .POLY   (POLY)
    ) u_misr_core (
        .sig     (sig_q),
        .data    (inj),
        .sig_nxt (misr_nxt)
    );

    // FSM state register
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) state_q <= IDLE;
        else                 state_q <= state_d;
    end

    // FSM next-state: start only honoured in IDLE, handshake closes DONE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (SETTLE == 0) ? CAPTURE : FLUSH;
            FLUSH:   if (cnt_q == SETTLE_LAST) state_d = CAPTURE;
            CAPTURE: if (cnt_q == WIN_LAST) state_d = DONE;
            DONE:    if (hs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy = (state_q != IDLE);
    end

    // Counter and signature next-values per phase
    always_comb begin
        cnt_d = cnt_q;
        sig_d = sig_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                sig_d = SEED;
            end
            FLUSH: begin
                if (cnt_q == SETTLE_LAST) cnt_d = '0;
                else                      cnt_d = cnt_q + CNT_W'(1);
            end
            CAPTURE: begin
                sig_d = misr_nxt;
                if (cnt_q != WIN_LAST) cnt_d = cnt_q + CNT_W'(1);
            end
            default: ;
        endcase
    end

    // Output stage: signature, valid and pass registered one cycle into DONE;
    // pass re-evaluates exp_sig every DONE cycle
    always_comb begin
        resp_d      = resp_in;
        sig_valid_d = (state_q == DONE) && !hs;
        sig_data_d  = sig_valid_d ? sig_q : '0;
        pass_d      = sig_valid_d && (sig_q == exp_sig);
    end

    // Datapath and output registers
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            cnt_q       <= '0;
            sig_q       <= '0;
            resp_q      <= '0;
            sig_valid_q <= 1'b0;
            sig_data_q  <= '0;
            pass_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            sig_q       <= sig_d;
            resp_q      <= resp_d;
            sig_valid_q <= sig_valid_d;
            sig_data_q  <= sig_data_d;
            pass_q      <= pass_d;
        end
    end

    assign sig_valid = sig_valid_q;
    assign sig_data  = sig_data_q;
    assign pass      = pass_q;

endmodule

// File: tb/tb_pattern_resp_misr.sv
// Bench for pattern_resp_misr: a minimal-window instance (SETTLE=0,
// WIN_LEN=1) driven from a vector table, and a default-parameter instance
// checked against an independent bitwise MISR model.
module tb_pattern_resp_misr;

    localparam int B_SET = 2;
    localparam int B_WIN = 256;
    localparam logic [15:0] TAPS = 16'hB400;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start_a = 0, ready_a = 0, busy_a, valid_a, pass_a;
    logic [8:0]  resp_a = '0;
    logic [15:0] exp_a = '0, data_a;
    logic        start_b = 0, ready_b = 0, busy_b, valid_b, pass_b;
    logic [8:0]  resp_b = '0;
    logic [15:0] exp_b = '0, data_b;
`ifdef PATTERN_RESP_MISR_MASK_EN
    logic [8:0]  mask_a = '0;
    logic [8:0]  mask_b = '0;
`endif

    int checks = 0;
    int failures = 0;

    pattern_resp_misr #(.SETTLE(0), .WIN_LEN(1)) u_a (
        .blif_clk_net   (clk),
        .blif_reset_net (rst_n),
        .start          (start_a),
        .resp_in        (resp_a),
`ifdef PATTERN_RESP_MISR_MASK_EN
        .resp_mask      (mask_a),
`endif
        .exp_sig        (exp_a),
        .busy           (busy_a),
        .sig_valid      (valid_a),
        .sig_ready      (ready_a),
        .sig_data       (data_a),
        .pass           (pass_a)
    );

    pattern_resp_misr u_b (
        .blif_clk_net   (clk),
        .blif_reset_net (rst_n),
        .start          (start_b),
        .resp_in        (resp_b),
`ifdef PATTERN_RESP_MISR_MASK_EN
        .resp_mask      (mask_b),
`endif
        .exp_sig        (exp_b),
        .busy           (busy_b),
        .sig_valid      (valid_b),
        .sig_ready      (ready_b),
        .sig_data       (data_b),
        .pass           (pass_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Bitwise reference: new[i] = old[i+1] ^ (old[0] & taps[i]) ^ data[i]
    function automatic logic [15:0] ref_step(logic [15:0] s, logic [8:0] d);
        logic [16:0] ext;
        logic [15:0] dd;
        logic [15:0] n;
        ext = {1'b0, s};
        dd  = {7'b0, d};
        for (int i = 0; i < 16; i++)
            n[i] = ext[i+1] ^ (s[0] & TAPS[i]) ^ dd[i];
        return n;
    endfunction

    // One full run on u_b; optionally pokes start during FLUSH and CAPTURE.
    // model_zero makes the model absorb zeros while random data is driven.
    task automatic run_b(input bit poke, input bit model_zero, output logic [15:0] m);
        logic [8:0] v;
        m = 16'hFFFF;
        for (int k = 0; k < B_SET + B_WIN; k++) begin
            v = 9'($urandom_range(0, 511));
            resp_b  = v;
            start_b = (k == 0) || (poke && (k == 1 || k == B_SET + 5));
            if (k >= B_SET) m = ref_step(m, model_zero ? 9'h0 : v);
            @(posedge clk); #1;
            if (k == 0) chk("b_busy_after_start", busy_b, 1);
        end
        start_b = 0;
        exp_b   = m;
        chk("b_valid_not_early", valid_b, 0);
        @(posedge clk); #1;
        chk("b_valid_not_early2", valid_b, 0);
        @(posedge clk); #1;
        chk("b_valid_rise", valid_b, 1);
        chk("b_sig_data", data_b, m);
        chk("b_pass", pass_b, 1);
    endtask

    task automatic handshake_b();
        ready_b = 1;
        @(posedge clk); #1;
        ready_b = 0;
        chk("b_valid_after_hs", valid_b, 0);
        chk("b_busy_after_hs", busy_b, 0);
    endtask

    typedef struct {
        logic [8:0]  resp;
        logic [15:0] exp_sig;
        logic [15:0] want_data;
        logic        want_pass;
    } vec_t;

    vec_t vecs [6];
    logic [15:0] m;

    initial begin
        vecs[0] = '{9'h000, 16'hCBFF, 16'hCBFF, 1'b1};
        vecs[1] = '{9'h1FF, 16'hCBFF, 16'hCA00, 1'b0};
        vecs[2] = '{9'h001, 16'hCBFE, 16'hCBFE, 1'b1};
        vecs[3] = '{9'h100, 16'h0000, 16'hCAFF, 1'b0};
        vecs[4] = '{9'h0AA, 16'hCB55, 16'hCB55, 1'b1};
        vecs[5] = '{9'h155, 16'hCAAA, 16'hCAAA, 1'b1};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy_a", busy_a, 0);
        chk("rst_valid_b", valid_b, 0);
        chk("rst_data_b", data_b, 0);
        rst_n = 1;
        @(posedge clk); #1;
        chk("idle_busy_b", busy_b, 0);
        chk("idle_pass_a", pass_a, 0);

        // Minimal window: valid two edges after start
        for (int i = 0; i < 6; i++) begin
            resp_a  = vecs[i].resp;
            exp_a   = vecs[i].exp_sig;
            start_a = 1;
            @(posedge clk); #1;
            start_a = 0;
            chk("a_busy", busy_a, 1);
            chk("a_valid_t1", valid_a, 0);
            @(posedge clk); #1;
            chk("a_valid_t2", valid_a, 0);
            @(posedge clk); #1;
            chk("a_valid", valid_a, 1);
            chk("a_data", data_a, vecs[i].want_data);
            chk("a_pass", pass_a, vecs[i].want_pass);
            ready_a = 1;
            @(posedge clk); #1;
            ready_a = 0;
            chk("a_valid_hs", valid_a, 0);
            chk("a_busy_hs", busy_a, 0);
        end

        // Start together with the handshake in DONE is dropped
        resp_a = 9'h000; exp_a = 16'hCBFF; start_a = 1;
        @(posedge clk); #1; start_a = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("a_valid_pre", valid_a, 1);
        start_a = 1; ready_a = 1;
        @(posedge clk); #1;
        start_a = 0; ready_a = 0;
        chk("a_same_cycle_valid", valid_a, 0);
        chk("a_same_cycle_busy", busy_a, 0);
        @(posedge clk); #1;
        chk("a_start_dropped", busy_a, 0);

        // Default instance: stall 10 cycles, then pass lag, then handshake
        run_b(1'b0, 1'b0, m);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("b_stall_valid", valid_b, 1);
            chk("b_stall_data", data_b, m);
        end
        exp_b = m ^ 16'h0001;
        chk("b_pass_lag", pass_b, 1);
        @(posedge clk); #1;
        chk("b_pass_drop", pass_b, 0);
        exp_b = m;
        @(posedge clk); #1;
        chk("b_pass_back", pass_b, 1);
        handshake_b();

        // Start pokes in FLUSH and CAPTURE must not restart the run
        run_b(1'b1, 1'b0, m);
        handshake_b();

        // Asynchronous reset mid-CAPTURE (u_b) and in DONE (u_a)
        resp_a = 9'h000; exp_a = 16'hCBFF;
        start_a = 1; start_b = 1;
        @(posedge clk); #1;
        start_a = 0; start_b = 0;
        repeat (6) @(posedge clk);
        #2;
        chk("a_valid_before_rst", valid_a, 1);
        chk("b_busy_before_rst", busy_b, 1);
        rst_n = 0;
        #1;
        chk("arst_busy_b", busy_b, 0);
        chk("arst_valid_a", valid_a, 0);
        chk("arst_data_a", data_a, 0);
        chk("arst_pass_a", pass_a, 0);
        chk("arst_busy_a", busy_a, 0);
        @(posedge clk); #1;
        rst_n = 1;
        @(posedge clk); #1;
        run_b(1'b0, 1'b0, m);
        handshake_b();

`ifdef PATTERN_RESP_MISR_MASK_EN
        // Fully masked responses leave the all-zero-data signature
        mask_b = 9'h1FF;
        run_b(1'b0, 1'b1, m);
        handshake_b();
        mask_b = 9'h000;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pattern_resp_misr.md
# pattern_resp_misr

Downstream response compactor for the merged pattern netlist stage. It registers that stage's 9 output nets every cycle. Over a programmable capture window it folds them into a 16-bit multiple-input signature register (MISR). It then presents the signature, plus a pass/fail compare against an expected value, through a valid/ready handshake to the bench or BIST controller.

## Interface
Parameters:
- RESP_W, 9: response vector width; equals the upstream output count.
- SIG_W, 16: signature width.
- POLY, 16'hB400: Galois feedback taps, x^16+x^14+x^13+x^11+1.
- SEED, 16'hFFFF: signature value loaded on start.
- SETTLE, 2: cycles discarded after start, for upstream flops to refill; 0 is legal.
- WIN_LEN, 256: number of capture cycles; must be at least 1.

Ports:
- blif_clk_net, in, 1: single clock; all flops rise on it.
- blif_reset_net, in, 1: asynchronous, active-low reset.
- start, in, 1: one-cycle request to begin a run.
- resp_in, in, RESP_W: bit order 8..0 is {G42_1, n_572_1, n_573_1, n_549_1, n_569_1, ACVQN2_3, n_266_and_0_3, ACVQN1_5, P6_5}.
- exp_sig, in, SIG_W: golden signature; sampled while in DONE.
- busy, out, 1: high in FLUSH, CAPTURE and DONE.
- sig_valid, out, 1: signature ready.
- sig_ready, in, 1: consumer accept.
- sig_data, out, SIG_W: final signature.
- pass, out, 1: sig_data == exp_sig; meaningful only while sig_valid is high.

## Operation
- Input stage: resp_q <= resp_in every cycle, unconditionally.
- FSM states:
  - IDLE: start moves to FLUSH, or to CAPTURE if SETTLE==0. sig <= SEED, cnt <= 0.
  - FLUSH: cnt counts up to SETTLE-1, then moves to CAPTURE with cnt <= 0. sig holds.
  - CAPTURE: each cycle the MISR updates. fb = sig[0]; sig <= (sig>>1) ^ (fb ? POLY : 0) ^ zero-extended resp_q. When cnt == WIN_LEN-1, move to DONE.
  - DONE: sig_valid=1 and sig_data=sig, stable. sig_valid && sig_ready moves to IDLE.
- The counter is $clog2(max(WIN_LEN,SETTLE)+1) bits wide and never wraps.
- start is ignored unless the FSM is in IDLE; there is no queueing.
- Same-cycle start and handshake in DONE: the handshake completes, start is dropped, and the FSM returns to IDLE.
- sig_ready while not valid: ignored.
- Reset (any state, any cycle) forces:
  - FSM to IDLE;
  - sig, resp_q, cnt and sig_data to 0;
  - busy, sig_valid and pass to 0.

## Timing
- start is sampled at edge t. busy is high from t+1.
- First absorbed resp_q is resp_in sampled at edge t+SETTLE. Its MISR update lands at edge t+SETTLE+1.
- sig_valid rises at edge t+SETTLE+WIN_LEN+1.
- Total latency from start to sig_valid is SETTLE+WIN_LEN+1 cycles.
- Handshake at edge h: sig_valid and busy are 0 after h. A new start is accepted at edge h+1 at the earliest.
- pass is registered. It is updated each DONE cycle from the current exp_sig, so it tracks exp_sig with 1 cycle of lag.

## Configuration
- Macro: PATTERN_RESP_MISR_MASK_EN.
- Defined: adds input port resp_mask [RESP_W-1:0]. In CAPTURE the injected term is resp_q & ~resp_mask, so masked (X-prone) bits contribute 0.
- Not defined: no resp_mask port. Every bit of resp_q is injected.

## Structure
- Package pattern_resp_pkg holds:
  - the state enum {IDLE, FLUSH, CAPTURE, DONE};
  - default POLY and SEED localparams;
  - named bit-index constants for the 9 response nets.
- One sub-module, misr_core: combinational next-signature function (sig, data, POLY) -> next sig. It is instantiated once, so the polynomial can be swapped without touching the FSM.

## Test plan
- SETTLE=0, WIN_LEN=1, resp_in=0, start: sig_valid rises 2 cycles later with sig_data=16'hCBFF. pass=1 when exp_sig=16'hCBFF.
- Same setup with resp_in=9'h1FF: sig_data=16'hCA00. exp_sig=16'hCBFF gives pass=0.
- Defaults, sig_ready held low for 10 cycles in DONE: sig_valid and sig_data stay stable. Pulse sig_ready: sig_valid falls next cycle and busy=0.
- start pulsed while in CAPTURE: no restart, and the signature equals the single-run reference model.
- blif_reset_net asserted mid-CAPTURE: all outputs 0 immediately (asynchronously). After release, a fresh run matches the model.
- With MASK_EN: resp_mask=9'h1FF and random resp_in give sig_data equal to the all-zero-response signature.
